// File: rtl/speed_ramp_ctrl.sv
// speed_ramp_ctrl: turns up/down button requests into a saturating 2-bit target
// and ramps the PWM speed toward it one level per dwell period. Optional macro
// SPEED_RAMP_DEBOUNCE_EN adds a debouncer behind each button synchroniser.
module speed_ramp_ctrl #(
    parameter int unsigned STEP_CYCLES     = 1000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       estop,
    output logic [1:0] speed,
    output logic       motor_en,
    output logic       busy,
    output logic       at_target
);

    localparam int unsigned CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    if (STEP_CYCLES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("speed_ramp_ctrl: STEP_CYCLES must be >= 2, DEBOUNCE_CYCLES >= 1");
    end

    logic       up_s1_q, up_s2_q, dn_s1_q, dn_s2_q, es_s1_q, es_s2_q;
    logic       up_lvl, dn_lvl, up_prev_q, dn_prev_q, up_pls, dn_pls;
    logic [1:0] target_q, target_d, speed_q;
    logic [CW-1:0] cnt_q;
    state_t     state_q;
    logic       busy_q, motor_en_q;

    // Two-flop synchronisers for the asynchronous inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {up_s1_q, up_s2_q} <= 2'b00;
            {dn_s1_q, dn_s2_q} <= 2'b00;
            {es_s1_q, es_s2_q} <= 2'b00;
        end else begin
            {up_s1_q, up_s2_q} <= {btn_up, up_s1_q};
            {dn_s1_q, dn_s2_q} <= {btn_down, dn_s1_q};
            {es_s1_q, es_s2_q} <= {estop, es_s1_q};
        end
    end

`ifdef SPEED_RAMP_DEBOUNCE_EN
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          up_db_q, dn_db_q;
    logic [DW-1:0] up_dc_q, dn_dc_q;

    // Debounced level follows the input only after it has differed long enough
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_db_q <= 1'b0;
            dn_db_q <= 1'b0;
            up_dc_q <= '0;
            dn_dc_q <= '0;
        end else begin
            if (up_s2_q == up_db_q) begin
                up_dc_q <= '0;
            end else if (up_dc_q == DB_LAST) begin
                up_db_q <= up_s2_q;
                up_dc_q <= '0;
            end else begin
                up_dc_q <= up_dc_q + 1'b1;
            end
            if (dn_s2_q == dn_db_q) begin
                dn_dc_q <= '0;
            end else if (dn_dc_q == DB_LAST) begin
                dn_db_q <= dn_s2_q;
                dn_dc_q <= '0;
            end else begin
                dn_dc_q <= dn_dc_q + 1'b1;
            end
        end
    end

    assign up_lvl = up_db_q;
    assign dn_lvl = dn_db_q;
`else
    assign up_lvl = up_s2_q;
    assign dn_lvl = dn_s2_q;
`endif

    // Previous button levels for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_prev_q <= 1'b0;
            dn_prev_q <= 1'b0;
        end else begin
            up_prev_q <= up_lvl;
            dn_prev_q <= dn_lvl;
        end
    end

    assign up_pls = up_lvl & ~up_prev_q;
    assign dn_pls = dn_lvl & ~dn_prev_q;

    // Saturating target update; simultaneous up and down cancel
    always_comb begin
        target_d = target_q;
        if (up_pls && !dn_pls && target_q != 2'd3) begin
            target_d = target_q + 2'd1;
        end else if (dn_pls && !up_pls && target_q != 2'd0) begin
            target_d = target_q - 2'd1;
        end
    end

    // Target register, forced to zero while estop is active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q <= 2'd0;
        end else if (es_s2_q) begin
            target_q <= 2'd0;
        end else begin
            target_q <= target_d;
        end
    end

    // Motor enable tracks the inverted synchronised estop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            motor_en_q <= 1'b0;
        end else begin
            motor_en_q <= ~es_s2_q;
        end
    end

    // Ramp FSM: dwell STEP_CYCLES per level, re-evaluate direction every edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            speed_q <= 2'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (es_s2_q) begin
            state_q <= IDLE;
            speed_q <= 2'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                RAMP_UP: begin
                    if (target_q < speed_q) begin
                        state_q <= RAMP_DOWN;
                        cnt_q   <= '0;
                    end else if (target_q == speed_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        speed_q <= speed_q + 2'd1;
                        cnt_q   <= '0;
                        if (speed_q + 2'd1 == target_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RAMP_DOWN: begin
                    if (target_q > speed_q) begin
                        state_q <= RAMP_UP;
                        cnt_q   <= '0;
                    end else if (target_q == speed_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        speed_q <= speed_q - 2'd1;
                        cnt_q   <= '0;
                        if (speed_q - 2'd1 == target_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q <= '0;
                    if (target_q > speed_q) begin
                        state_q <= RAMP_UP;
                        busy_q  <= 1'b1;
                    end else if (target_q < speed_q) begin
                        state_q <= RAMP_DOWN;
                        busy_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign speed     = speed_q;
    assign motor_en  = motor_en_q;
    assign busy      = busy_q;
    assign at_target = (speed_q == target_q);

endmodule

// File: tb/tb_speed_ramp_ctrl.sv
// tb_speed_ramp_ctrl: vector table, hand sequences and random stimulus
// checked against a cycle-level reference model of the ramp controller.
module tb_speed_ramp_ctrl;

    localparam int STEP = 4;
    localparam int DB   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, estop = 1'b0;
    logic [1:0] speed;
    logic       motor_en, busy, at_target;

    int n_err = 0;
    int n_chk = 0;
    bit mon_en = 1'b0;

    speed_ramp_ctrl #(.STEP_CYCLES(STEP), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
        .estop(estop), .speed(speed), .motor_en(motor_en),
        .busy(busy), .at_target(at_target)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples per edge, pulse when high two edges ago
    // and low three edges ago; ramp dwells STEP edges per level.
    int uh[4], dh[4], eh[4];
    int m_spd, m_tgt, m_mode, m_el, m_men;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                uh[k] = 0; dh[k] = 0; eh[k] = 0;
            end
            m_spd = 0; m_tgt = 0; m_mode = 0; m_el = 0; m_men = 0;
        end else begin
            int want;
            bit up_p, dn_p;
            for (int k = 3; k > 0; k--) begin
                uh[k] = uh[k-1]; dh[k] = dh[k-1]; eh[k] = eh[k-1];
            end
            uh[0] = int'(btn_up); dh[0] = int'(btn_down); eh[0] = int'(estop);
            up_p = (uh[2] == 1) && (uh[3] == 0);
            dn_p = (dh[2] == 1) && (dh[3] == 0);
            m_men = (eh[2] == 1) ? 0 : 1;
            if (eh[2] == 1) begin
                m_spd = 0; m_tgt = 0; m_mode = 0; m_el = 0;
            end else begin
                want = (m_tgt > m_spd) ? 1 : (m_tgt < m_spd) ? -1 : 0;
                if (want != m_mode) begin
                    m_mode = want;
                    m_el = 0;
                end else if (m_mode != 0) begin
                    m_el++;
                    if (m_el == STEP) begin
                        m_spd += m_mode;
                        m_el = 0;
                        if (m_spd == m_tgt) m_mode = 0;
                    end
                end
                if (up_p && !dn_p && m_tgt < 3) m_tgt++;
                else if (dn_p && !up_p && m_tgt > 0) m_tgt--;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("mdl_speed", int'(speed), m_spd);
            chk("mdl_busy", int'(busy), (m_mode != 0) ? 1 : 0);
            chk("mdl_at_target", int'(at_target), (m_spd == m_tgt) ? 1 : 0);
            chk("mdl_motor_en", int'(motor_en), m_men);
        end
    end

    task automatic drive(input logic u, input logic d, input logic e, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            btn_up = u; btn_down = d; estop = e;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; estop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_for(input string nm, input int spd, input int lim);
        int i;
        i = 0;
        while (!(int'(speed) == spd && !busy) && i < lim) begin
            @(negedge clk);
            i++;
        end
        chk(nm, (int'(speed) == spd && !busy) ? 1 : 0, 1);
    endtask

    typedef struct {
        logic       u, d, e;
        logic [1:0] spd;
        logic       bsy, at, men;
    } vec_t;

    vec_t tbl[22];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
        for (int i = 3; i < 7; i++)
            tbl[i] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
        for (int i = 12; i < 15; i++)
            tbl[i] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
        for (int i = 19; i < 22; i++)
            tbl[i] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};

        // Reset values while rst is held
        repeat (3) @(negedge clk);
        chk("rst_speed", int'(speed), 0);
        chk("rst_motor_en", int'(motor_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_at_target", int'(at_target), 1);
        @(negedge clk);
        rst = 1'b0;

`ifndef SPEED_RAMP_DEBOUNCE_EN
        mon_en = 1'b1;

        // Single press, estop, presses during estop, release, up+down together
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            btn_up = tbl[i].u; btn_down = tbl[i].d; estop = tbl[i].e;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_speed", i), int'(speed), int'(tbl[i].spd));
            chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].bsy));
            chk($sformatf("v%0d_at", i), int'(at_target), int'(tbl[i].at));
            chk($sformatf("v%0d_men", i), int'(motor_en), int'(tbl[i].men));
        end

        // Saturation: four spaced presses reach 3 and stop there
        do_reset();
        repeat (4) begin
            drive(1'b1, 1'b0, 1'b0, 1);
            drive(1'b0, 1'b0, 1'b0, 1);
        end
        wait_for("sat_reach3", 3, 40);
        drive(1'b0, 1'b0, 1'b0, 10);
        chk("sat_hold_speed", int'(speed), 3);
        chk("sat_at_target", int'(at_target), 1);

        // Reversal at speed 2 while heading for 3
        do_reset();
        repeat (3) begin
            drive(1'b1, 1'b0, 1'b0, 1);
            drive(1'b0, 1'b0, 1'b0, 1);
        end
        begin
            int i;
            i = 0;
            while (int'(speed) != 2 && i < 40) begin
                @(negedge clk);
                i++;
            end
            chk("rev_reach2", int'(speed), 2);
        end
        repeat (2) begin
            drive(1'b0, 1'b1, 1'b0, 1);
            drive(1'b0, 1'b0, 1'b0, 1);
        end
        wait_for("rev_settle1", 1, 30);

        // Asynchronous reset in the middle of a ramp
        drive(1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 5);
        chk("midrst_busy_before", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_speed", int'(speed), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_at", int'(at_target), 1);
        chk("midrst_men", int'(motor_en), 0);
        @(negedge clk);
        rst = 1'b0;

        // Random stimulus against the model
        begin
            int es_len;
            es_len = 0;
            for (int c = 0; c < 4000; c++) begin
                @(negedge clk);
                if (rst) rst = 1'b0;
                else if ($urandom % 1500 == 0) rst = 1'b1;
                if (es_len > 0) es_len--;
                else if ($urandom % 250 == 0) es_len = $urandom_range(2, 12);
                estop = (es_len > 0);
                btn_up = ($urandom % 5 == 0);
                btn_down = ($urandom % 6 == 0);
            end
            @(negedge clk);
            rst = 1'b0; estop = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
            repeat (4) @(negedge clk);
        end
        mon_en = 1'b0;
`else
        // Glitch shorter than the debounce window, then a long press
        drive(1'b1, 1'b0, 1'b0, 5);
        drive(1'b0, 1'b0, 1'b0, 40);
        chk("db_glitch_speed", int'(speed), 0);
        chk("db_glitch_busy", int'(busy), 0);
        drive(1'b1, 1'b0, 1'b0, 12);
        drive(1'b0, 1'b0, 1'b0, 1);
        wait_for("db_press_speed1", 1, 60);
        drive(1'b0, 1'b0, 1'b0, 40);
        chk("db_press_once", int'(speed), 1);
        chk("db_press_at", int'(at_target), 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
